// File: rtl/clap_laser_ctrl_pkg.sv
// rtl/clap_laser_ctrl_pkg.sv - shared encodings and helpers for the clap laser controller
//
// Purpose : laser mode encodings, controller FSM state encoding and small
//           helper functions shared by the controller files.
// Ports   : none (package)
package clap_laser_ctrl_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKOUT = 2'd1,
    ST_LISTEN  = 2'd2,
    ST_DECIDE  = 2'd3
  } state_e;

  // Number of claps in a window -> commanded mode.
  function automatic logic [1:0] clap_to_mode(input logic [1:0] count);
    logic [1:0] m;
    case (count)
      2'd1:    m = MODE_ON;
      2'd2:    m = MODE_OFF;
      2'd3:    m = MODE_BLINK;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

  // Clap count increment, saturating at 3.
  function automatic logic [1:0] clap_inc_sat(input logic [1:0] count);
    return (count == 2'd3) ? 2'd3 : count + 2'd1;
  endfunction

endpackage

// File: rtl/clap_edge_sync.sv
// rtl/clap_edge_sync.sv - 2-FF synchroniser with registered rising-edge pulse
//
// Purpose : brings an asynchronous sensor level into the clk domain and
//           emits a one-cycle pulse on each synchronised rising edge.
//           The pulse is visible after the third clk edge following din rising.
// Ports   : clk   - system clock
//           rst_n - asynchronous active-low reset
//           din   - asynchronous input level
//           rise  - one-cycle pulse on rising edge of din
module clap_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign rise = r_rise;

endmodule

// File: rtl/clap_laser_ctrl.sv
// rtl/clap_laser_ctrl.sv - clap-driven laser mode controller
//
// Purpose : counts claps inside a decision window (with a lockout after each
//           accepted clap) and at window close applies ON / OFF / BLINK.
// Ports   : clk        - system clock
//           rst_n      - asynchronous active-low reset
//           aplauso    - raw clap comparator output, asynchronous to clk
//           enable     - 1 = active; 0 = abort sequence and force laser off
//           laser      - laser driver output
//           mode       - current mode (00 OFF, 01 ON, 10 BLINK)
//           clap_count - claps counted in the current window, saturating at 3
//           cmd_valid  - one-cycle pulse when a command is applied
module clap_laser_ctrl
  import clap_laser_ctrl_pkg::*;
#(
  parameter int LOCKOUT_CYC    = 5_000_000,
  parameter int WINDOW_CYC     = 100_000_000,
  parameter int BLINK_HALF_CYC = 12_500_000,
  parameter int CNT_W          = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       aplauso,
  input  logic       enable,
  output logic       laser,
  output logic [1:0] mode,
  output logic [1:0] clap_count,
  output logic       cmd_valid
);

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYC - 1);
  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WINDOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             w_rise;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0] w_lock_nxt;
  logic [CNT_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] w_win_nxt;
  logic [CNT_W-1:0] r_blink_cnt;
  logic [CNT_W-1:0] w_blink_nxt;
  logic [1:0]       r_clap_cnt;
  logic [1:0]       w_clap_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic             r_blink_ph;
  logic             w_blink_ph_nxt;
  logic             w_win_last;

  clap_edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (aplauso),
    .rise  (w_rise)
  );

  assign w_win_last = (r_win_cnt == WIN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lock_cnt  <= '0;
      r_win_cnt   <= '0;
      r_blink_cnt <= '0;
      r_clap_cnt  <= 2'd0;
      r_mode      <= MODE_OFF;
      r_blink_ph  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_nxt;
      r_win_cnt   <= w_win_nxt;
      r_blink_cnt <= w_blink_nxt;
      r_clap_cnt  <= w_clap_nxt;
      r_mode      <= w_mode_nxt;
      r_blink_ph  <= w_blink_ph_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_nxt     = r_lock_cnt;
    w_win_nxt      = r_win_cnt;
    w_clap_nxt     = r_clap_cnt;
    w_mode_nxt     = r_mode;
    w_blink_nxt    = '0;
    w_blink_ph_nxt = 1'b1;

    // Blink waveform; the phase sits at 1 outside BLINK so entering BLINK
    // always starts with the laser on.
    if (r_mode == MODE_BLINK) begin
      w_blink_ph_nxt = r_blink_ph;
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_nxt    = '0;
        w_blink_ph_nxt = ~r_blink_ph;
      end else begin
        w_blink_nxt = r_blink_cnt + CNT_ONE;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_clap_nxt  = 2'd1;
          w_win_nxt   = '0;
          w_lock_nxt  = '0;
          w_state_nxt = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT, ST_LISTEN: begin
        // Window expiry wins over anything else this cycle, including an edge.
        if (w_win_last) begin
          w_state_nxt    = ST_DECIDE;
          w_mode_nxt     = clap_to_mode(r_clap_cnt);
          w_blink_nxt    = '0;
          w_blink_ph_nxt = 1'b1;
        end else begin
          w_win_nxt = r_win_cnt + CNT_ONE;
          if (r_state == ST_LOCKOUT) begin
            if (r_lock_cnt == LOCK_LAST) begin
              w_lock_nxt  = '0;
              w_state_nxt = ST_LISTEN;
            end else begin
              w_lock_nxt = r_lock_cnt + CNT_ONE;
            end
          end else if (w_rise) begin
            w_clap_nxt  = clap_inc_sat(r_clap_cnt);
            w_lock_nxt  = '0;
            w_state_nxt = ST_LOCKOUT;
          end
        end
      end
      ST_DECIDE: begin
        w_clap_nxt  = 2'd0;
        w_win_nxt   = '0;
        w_lock_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Disable aborts the sequence but keeps the mode; blink restarts at 1.
    if (!enable) begin
      w_state_nxt    = ST_IDLE;
      w_clap_nxt     = 2'd0;
      w_win_nxt      = '0;
      w_lock_nxt     = '0;
      w_blink_nxt    = '0;
      w_blink_ph_nxt = 1'b1;
    end
  end

  // Mode is applied on entry to DECIDE, so cmd_valid coincides with the new mode.
  assign cmd_valid  = (r_state == ST_DECIDE);
  assign mode       = r_mode;
  assign clap_count = enable ? r_clap_cnt : 2'd0;
  assign laser      = enable & ((r_mode == MODE_ON) |
                                ((r_mode == MODE_BLINK) & r_blink_ph));

endmodule

// File: tb/tb_clap_laser_ctrl.sv
// tb/tb_clap_laser_ctrl.sv - scoreboard testbench for clap_laser_ctrl
module tb_clap_laser_ctrl;

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] count;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       aplauso;
  logic       enable;
  logic       laser;
  logic [1:0] mode;
  logic [1:0] clap_count;
  logic       cmd_valid;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cmd_total = 0;

  clap_laser_ctrl #(
    .LOCKOUT_CYC    (4),
    .WINDOW_CYC     (20),
    .BLINK_HALF_CYC (3),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .aplauso    (aplauso),
    .enable     (enable),
    .laser      (laser),
    .mode       (mode),
    .clap_count (clap_count),
    .cmd_valid  (cmd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every command pulse is compared against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid) begin
        cmd_total++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd: got cmd_valid with mode %0d count %0d, expected none",
                   mode, clap_count);
        end else begin
          e = q.pop_front();
          check("cmd_mode", int'(mode), int'(e.mode));
          check("cmd_count", int'(clap_count), int'(e.count));
          check("cmd_laser", int'(laser), (e.mode != M_OFF) ? 1 : 0);
        end
      end
    end
  end

  // One clap: aplauso high for one cycle; the next clap edge comes gap cycles later.
  task automatic clap(input int gap);
    aplauso = 1'b1;
    @(negedge clk);
    aplauso = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic wait_cmd(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_valid && n < budget);
    if (!cmd_valid) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: got no cmd_valid within %0d cycles, expected one", budget);
    end
  endtask

  task automatic check_blink(input string name, input int cycles);
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      check(name, int'(laser), ((i % 6) < 3) ? 1 : 0);
    end
  endtask

  initial begin
    int n;
    int cmd_before;
    rst_n   = 1'b0;
    aplauso = 1'b0;
    enable  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_laser", int'(laser), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_count", int'(clap_count), 0);
    check("rst_cmd", int'(cmd_valid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single clap -> ON; command 24 negedges after aplauso rises
    q.push_back('{mode: M_ON, count: 2'd1});
    aplauso = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) aplauso = 1'b0;
    end while (!cmd_valid && n < 60);
    check("t1_latency", n, 24);
    @(negedge clk);
    check("t1_count_clr", int'(clap_count), 0);
    check("t1_mode", int'(mode), 1);
    check("t1_laser", int'(laser), 1);
    repeat (3) @(negedge clk);

    // 2: two claps 8 apart -> OFF, exactly one command
    cmd_before = cmd_total;
    q.push_back('{mode: M_OFF, count: 2'd2});
    clap(8);
    clap(2);
    wait_cmd(40);
    @(negedge clk);
    check("t2_mode", int'(mode), 0);
    check("t2_laser", int'(laser), 0);
    repeat (25) @(negedge clk);
    check("t2_one_cmd", cmd_total - cmd_before, 1);

    // 3a: three claps 6 apart -> BLINK, 3 on / 3 off
    q.push_back('{mode: M_BLINK, count: 2'd3});
    clap(6);
    clap(6);
    clap(2);
    wait_cmd(40);
    check_blink("t3_blink", 8);
    repeat (4) @(negedge clk);

    // 3b: five claps (last on the expiry cycle) -> count saturates, blink phase restarts
    q.push_back('{mode: M_BLINK, count: 2'd3});
    clap(5);
    clap(5);
    clap(5);
    clap(5);
    clap(1);
    wait_cmd(40);
    check_blink("t3_restart", 4);
    repeat (4) @(negedge clk);

    // 4: clap inside lockout ignored; clap on the expiry cycle dropped -> ON
    q.push_back('{mode: M_ON, count: 2'd1});
    clap(2);
    clap(18);
    clap(1);
    wait_cmd(40);
    @(negedge clk);
    check("t4_mode", int'(mode), 1);
    repeat (4) @(negedge clk);

    // 5: get BLINK, then abort mid-window after two claps
    q.push_back('{mode: M_BLINK, count: 2'd3});
    clap(6);
    clap(6);
    clap(2);
    wait_cmd(40);
    repeat (4) @(negedge clk);
    clap(8);
    clap(3);
    repeat (4) @(negedge clk);
    check("t5_count_pre", int'(clap_count), 2);
    cmd_before = cmd_total;
    enable = 1'b0;
    #1;
    check("t5_count_off", int'(clap_count), 0);
    check("t5_laser_off", int'(laser), 0);
    check("t5_mode_kept", int'(mode), 2);
    repeat (30) @(negedge clk);
    check("t5_no_cmd", cmd_total - cmd_before, 0);
    check("t5_laser_hold", int'(laser), 0);
    enable = 1'b1;
    #1;
    check("t5_laser_resume", int'(laser), 1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("t5_resume_blink", int'(laser), (i < 3) ? 1 : 0);
    end
    repeat (4) @(negedge clk);

    // 6: asynchronous reset mid-lockout, then a fresh single clap -> ON with count 1
    clap(5);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_laser", int'(laser), 0);
    check("t6_mode", int'(mode), 0);
    check("t6_count", int'(clap_count), 0);
    check("t6_cmd", int'(cmd_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    q.push_back('{mode: M_ON, count: 2'd1});
    clap(2);
    wait_cmd(40);
    repeat (25) @(negedge clk);

    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clap_laser_ctrl.md
Name: clap_laser_ctrl

Overview:
Laser mode controller driven by a clap (microphone comparator) input. It synchronises the input, detects rising edges, and counts claps inside a fixed decision window, with a refractory lockout after each clap. At window close it issues one command: ON, OFF or BLINK. It sits between the microphone comparator pin and the laser driver pin, and replaces ad-hoc clap handling in the top level.

Parameters:
LOCKOUT_CYC, 5_000_000, cycles after each accepted clap during which further edges are ignored (100 ms at 50 MHz)
WINDOW_CYC, 100_000_000, decision window length in cycles, measured from the first clap (2 s at 50 MHz)
BLINK_HALF_CYC, 12_500_000, half-period of the blink waveform in cycles
CNT_W, 27, width of the lockout, window and blink counters; must hold max(WINDOW_CYC, LOCKOUT_CYC, BLINK_HALF_CYC)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
aplauso  in  1  raw clap comparator output; asynchronous to clk
enable  in  1  1 = controller active; 0 = abort sequence and force laser off
laser  out  1  laser driver
mode  out  2  current mode: 00 OFF, 01 ON, 10 BLINK
clap_count  out  2  claps counted in the current window; saturates at 3
cmd_valid  out  1  one-cycle pulse when a command is applied

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all counters 0
  - laser=0, mode=00, clap_count=0, cmd_valid=0
- Input conditioning:
  - 2-FF synchroniser on aplauso, then rising-edge detect
  - edge pulse asserts 3 clk edges after aplauso rises (worst case)
- FSM states: IDLE, LOCKOUT, LISTEN, DECIDE.
- IDLE:
  - on edge: clap_count=1, clear window and lockout counters, go to LOCKOUT
- LOCKOUT:
  - edges ignored
  - lockout counter increments; when it equals LOCKOUT_CYC-1, go to LISTEN
- LISTEN:
  - on edge: clap_count=min(clap_count+1, 3), clear lockout counter, go to LOCKOUT
- Window counter:
  - runs in LOCKOUT and LISTEN
  - when it equals WINDOW_CYC-1, go to DECIDE next cycle, from either state
  - window expiry takes priority over a same-cycle edge; that edge is dropped
- DECIDE (exactly 1 cycle):
  - cmd_valid=1
  - clap_count 1 -> mode=01; 2 -> mode=00; 3 -> mode=10
  - next cycle: clap_count=0, state=IDLE
  - edges during DECIDE are ignored
- Laser output:
  - mode 00 -> laser=0; mode 01 -> laser=1
  - mode 10:
    - laser=1 on the cycle mode becomes 10
    - toggles every BLINK_HALF_CYC cycles
    - blink counter cleared on every mode change
  - re-commanding the same mode restarts the blink phase (counter cleared, laser=1)
- enable=0:
  - takes effect the same cycle: state=IDLE, clap_count=0, counters cleared, laser=0
  - mode is retained and no cmd_valid is issued
  - on enable rising, laser resumes per mode; blink phase restarts at 1
- Reset mid-sequence: immediate return to reset values; no command issued.
- Counters never wrap: each is compared against its limit and cleared.

Decomposition:
- Shared header (`include`):
  - mode encodings MODE_OFF=2'b00, MODE_ON=2'b01, MODE_BLINK=2'b10
  - FSM state encodings
- One sub-module: clap_edge_sync
  - 2-FF synchroniser plus rising-edge pulse; ports clk, rst_n, din, rise
  - reusable by other sensor inputs

Test Plan (use LOCKOUT_CYC=4, WINDOW_CYC=20, BLINK_HALF_CYC=3):
1. One clap at t0 -> cmd_valid pulses once ~20 cycles after the edge is detected; mode=01, laser=1, clap_count returns to 0.
2. Two claps 8 cycles apart, after mode=01 -> mode=00, laser=0, exactly one cmd_valid.
3. Three claps 6 cycles apart -> mode=10:
   - laser=1 for 3 cycles, then 0 for 3 cycles, repeating
   - five claps in the window -> clap_count saturates at 3, same result
4. Second clap 2 cycles after the first (inside lockout) -> ignored, clap_count=1, mode=01; a clap landing exactly on the window-expiry cycle is dropped.
5. enable deasserted mid-window after 2 claps:
   - no cmd_valid, clap_count=0, laser=0, mode unchanged
   - re-enable with mode=10 -> laser restarts at 1
6. rst_n pulsed low asynchronously mid-LOCKOUT, off a clock edge -> outputs 0 immediately; next clap after release starts a fresh count at 1.
